// File: rtl/alu_mul_seq.sv
// Sequential 16x16->32 unsigned shift-add multiplier that borrows one shared 16-bit ALU, one bit per clock.
// Optional ALU bypass port (idle-time sharing) enabled by defining ALU_MUL_SEQ_BYPASS_EN.
module alu_mul_seq #(
  parameter logic [3:0] ADD_OP           = 4'b1001,
  parameter logic       ADD_MODE         = 1'b0,
  parameter bit         CARRY_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [3:0]  alu_op,
  output logic        alu_mode,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_c_in,
  input  logic [15:0] alu_z,
  input  logic        alu_c_out
`ifdef ALU_MUL_SEQ_BYPASS_EN
  ,
  input  logic        byp_req,
  input  logic [3:0]  byp_alu_op,
  input  logic        byp_mode,
  input  logic [15:0] byp_x,
  input  logic [15:0] byp_y,
  input  logic        byp_c_in,
  output logic        byp_gnt,
  output logic [15:0] byp_z,
  output logic        byp_c_out
`endif
);

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 4;
  localparam logic NO_CARRY  = CARRY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [W-1:0]    mc_q, mc_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mc_q      <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state: one shift-add step per RUN cycle, ALU result folded back into the accumulator.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mc_d      = mc_q;
    product_d = product_q;
    cy        = alu_c_out ^ NO_CARRY;
    case (state_q)
      IDLE: begin
        if (start) begin
          mc_d    = mcand;
          acc_d   = {W'(0), mplier};
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {cy, alu_z, acc_q[W-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_CNT) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // ALU drive: multiply step in RUN, optional bypass grant in IDLE, quiet add of zeros otherwise.
  always_comb begin
    alu_op   = ADD_OP;
    alu_mode = ADD_MODE;
    alu_x    = '0;
    alu_y    = '0;
    alu_c_in = NO_CARRY;
`ifdef ALU_MUL_SEQ_BYPASS_EN
    byp_gnt  = 1'b0;
`endif
    if (state_q == RUN) begin
      alu_x = acc_q[PW-1:W];
      alu_y = acc_q[0] ? mc_q : W'(0);
    end
`ifdef ALU_MUL_SEQ_BYPASS_EN
    else if ((state_q == IDLE) && byp_req && !start && !reset) begin
      byp_gnt  = 1'b1;
      alu_op   = byp_alu_op;
      alu_mode = byp_mode;
      alu_x    = byp_x;
      alu_y    = byp_y;
      alu_c_in = byp_c_in;
    end
`endif
  end

`ifdef ALU_MUL_SEQ_BYPASS_EN
  assign byp_z     = alu_z;
  assign byp_c_out = alu_c_out;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: two instances (active-low and active-high carries) each driving a behavioural ALU.
module tb_alu_mul_seq;

  localparam logic [3:0] ADD_OP = 4'b1001;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] mcand, mplier;

  logic        busy0, done0, busy1, done1;
  logic [31:0] product0, product1;
  logic [3:0]  alu_op0, alu_op1;
  logic        alu_mode0, alu_mode1, alu_c_in0, alu_c_in1;
  logic [15:0] alu_x0, alu_y0, alu_x1, alu_y1;
  logic [16:0] r0, r1;

`ifdef ALU_MUL_SEQ_BYPASS_EN
  logic        byp_req, byp_mode, byp_c_in;
  logic [3:0]  byp_alu_op;
  logic [15:0] byp_x, byp_y;
  logic        byp_gnt0, byp_gnt1, byp_c_out0, byp_c_out1;
  logic [15:0] byp_z0, byp_z1;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  always #5 clk = ~clk;

  // Behavioural ALU: add only when op/mode select arithmetic add, otherwise a deliberately different result.
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic mode, input logic [15:0] x,
                                        input logic [15:0] y, input logic c_in, input logic cal);
    logic        cin;
    logic [16:0] s;
    if (op == ADD_OP && mode == 1'b0) begin
      cin = cal ? ~c_in : c_in;
      s   = {1'b0, x} + {1'b0, y} + 17'(cin);
      return {(cal ? ~s[16] : s[16]), s[15:0]};
    end
    return {1'b0, x ^ y};
  endfunction

  assign r0 = alu_f(alu_op0, alu_mode0, alu_x0, alu_y0, alu_c_in0, 1'b1);
  assign r1 = alu_f(alu_op1, alu_mode1, alu_x1, alu_y1, alu_c_in1, 1'b0);

  alu_mul_seq #(.ADD_OP(ADD_OP), .ADD_MODE(1'b0), .CARRY_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy0), .done(done0), .product(product0),
    .alu_op(alu_op0), .alu_mode(alu_mode0), .alu_x(alu_x0), .alu_y(alu_y0), .alu_c_in(alu_c_in0),
    .alu_z(r0[15:0]), .alu_c_out(r0[16])
`ifdef ALU_MUL_SEQ_BYPASS_EN
    , .byp_req(byp_req), .byp_alu_op(byp_alu_op), .byp_mode(byp_mode), .byp_x(byp_x), .byp_y(byp_y),
    .byp_c_in(byp_c_in), .byp_gnt(byp_gnt0), .byp_z(byp_z0), .byp_c_out(byp_c_out0)
`endif
  );

  alu_mul_seq #(.ADD_OP(ADD_OP), .ADD_MODE(1'b0), .CARRY_ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy1), .done(done1), .product(product1),
    .alu_op(alu_op1), .alu_mode(alu_mode1), .alu_x(alu_x1), .alu_y(alu_y1), .alu_c_in(alu_c_in1),
    .alu_z(r1[15:0]), .alu_c_out(r1[16])
`ifdef ALU_MUL_SEQ_BYPASS_EN
    , .byp_req(byp_req), .byp_alu_op(byp_alu_op), .byp_mode(byp_mode), .byp_x(byp_x), .byp_y(byp_y),
    .byp_c_in(byp_c_in), .byp_gnt(byp_gnt1), .byp_z(byp_z1), .byp_c_out(byp_c_out1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops the next expected product for that instance.
  always @(negedge clk) begin
    if (done0) begin
      if (exp0.size() == 0) check("unexpected_done_cal1", 32'(done0), 32'd0);
      else check("product_cal1", product0, exp0.pop_front());
    end
    if (done1) begin
      if (exp1.size() == 0) check("unexpected_done_cal0", 32'(done1), 32'd0);
      else check("product_cal0", product1, exp1.pop_front());
    end
  end

  // Issue one multiply, optionally inject an ignored start at RUN cycle inject_at, and check timing.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p, input int inject_at);
    int cyc, bc;
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    exp0.push_back(p);
    exp1.push_back(p);
`ifdef ALU_MUL_SEQ_BYPASS_EN
    #1;
    if (byp_req) check("byp_gnt_denied_by_start", 32'(byp_gnt0), 32'd0);
`endif
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bc  = 0;
    while (!done0 && cyc < 40) begin
      if (busy0) bc++;
      if (cyc == 2) check("run_alu_op", 32'(alu_op0), 32'(ADD_OP));
      if (cyc == inject_at) begin
        start = 1'b1; mcand = 16'h7777; mplier = 16'h2222;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_latency", 32'(cyc), 32'd17);
    check("busy_cycles", 32'(bc), 32'd16);
    @(negedge clk);
    check("done_one_pulse", 32'(done0), 32'd0);
    check("idle_alu_x", 32'(alu_x0), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
`ifdef ALU_MUL_SEQ_BYPASS_EN
    byp_req = 1'b0; byp_alu_op = ADD_OP; byp_mode = 1'b0; byp_x = '0; byp_y = '0; byp_c_in = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_product", product0, 32'd0);
    check("rst_alu_y", 32'(alu_y0), 32'd0);
    check("rst_c_in_cal1", 32'(alu_c_in0), 32'd1);
    check("rst_c_in_cal0", 32'(alu_c_in1), 32'd0);
    reset = 1'b0;

    run_op(16'h0003, 16'h0005, 32'h0000000F, 0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    run_op(16'h1234, 16'h0000, 32'h00000000, 0);
    run_op(16'h0000, 16'hABCD, 32'h00000000, 0);
    run_op(16'h0003, 16'h0005, 32'h0000000F, 5);
    repeat (20) @(negedge clk);

    // Reset in the middle of a run abandons it without a done pulse.
    mcand = 16'h00FF; mplier = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_busy", 32'(busy0), 32'd0);
    check("mid_reset_done", 32'(done0), 32'd0);
    check("mid_reset_product_cal1", product0, 32'd0);
    check("mid_reset_product_cal0", product1, 32'd0);
    repeat (20) @(negedge clk);

    run_op(16'h00FF, 16'h0101, 32'h0000FFFF, 0);
    run_op(16'h8000, 16'h8000, 32'h40000000, 0);
    run_op(16'hABCD, 16'h1234, 32'h0C374FA4, 0);

`ifdef ALU_MUL_SEQ_BYPASS_EN
    @(negedge clk);
    byp_req = 1'b1; byp_x = 16'h0010; byp_y = 16'h0001; byp_c_in = 1'b1;
    #1;
    check("byp_gnt", 32'(byp_gnt0), 32'd1);
    check("byp_z_cal1", 32'(byp_z0), 32'h0011);
    check("byp_z_cal0", 32'(byp_z1), 32'h0012);
    run_op(16'h0002, 16'h0003, 32'h00000006, 0);
    byp_req = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("outstanding_cal1", 32'(exp0.size()), 32'd0);
    check("outstanding_cal0", 32'(exp1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
